imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader for the single-cycle MIPS core. It receives a byte stream over a valid/ready handshake, packs it into 32-bit big-endian instruction words and writes them into instruction memory at consecutive word-aligned byte addresses starting at 0. It holds the CPU stalled until a complete load finishes. It is the writer side of the instruction memory, which the core's fetch path only reads.

## Interface
Parameters:
- NUM_WORDS, 16, instruction memory capacity in 32-bit words; legal word counts are 1..NUM_WORDS

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  synchronous, active-high
- start  in  1  single-cycle pulse that begins a load; ignored while a load is in progress
- byte_valid  in  1  source presents byte_data
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  32  byte address, always word-aligned (bits 1:0 = 0)
- imem_wdata  out  32  instruction word
- cpu_hold  out  1  high: CPU must not fetch or advance PC
- done  out  1  load completed successfully; level, held
- error  out  1  load aborted; level, held

## Operation
- Stream format: one header byte N (word count), then 4*N data bytes, most-significant byte first. With checksum enabled, one trailing checksum byte follows the data.
- A byte is accepted on a rising edge with byte_valid && byte_ready. The source may drop byte_valid at any time; gaps have no effect.
- States:
  - IDLE: no bytes accepted. start moves to HEADER and clears done, error, word counter and byte counter.
  - HEADER: byte_ready=1. On an accepted byte, N=0 or N>NUM_WORDS moves to ERR. Otherwise latch N and move to DATA.
  - DATA: byte_ready=1. Each accepted byte shifts into the packer; the first byte lands in bits 31:24. On the 4th byte of a word, the packed word is registered for writing. After the 4*N-th byte, move to CHECK (checksum enabled) or DONE (checksum disabled).
  - CHECK: byte_ready=1. Accept one byte, then move to DONE on match or ERR on mismatch.
  - DONE: done=1, cpu_hold=0. start moves to HEADER (reload).
  - ERR: error=1, cpu_hold=1. start moves to HEADER.
- Word k (0-based) is written at imem_addr = 4*k. The word counter never exceeds N-1, so addresses never wrap.
- start in HEADER, DATA or CHECK is ignored.
- Reset values: byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, error=0, state IDLE.
- Reset mid-load: immediately return to the reset values. Partially written words stay in memory. No further strobes are issued.

## Timing
- imem_we pulses for exactly one cycle: the cycle after the edge that accepts the 4th byte of a word. imem_addr and imem_wdata are valid in that same cycle and hold their values afterwards.
- Minimum 4 cycles per word at full rate. byte_ready stays high during the write strobe, so back-to-back bytes are never stalled.
- After the final data byte (checksum disabled), the last word's strobe and the done/cpu_hold transition occur on the same cycle: one cycle after acceptance.
- After the checksum byte, done or error asserts one cycle after acceptance.
- cpu_hold falls on the same cycle done rises.

## Configuration
- IMEM_LOADER_CHECKSUM_EN
  - Defined: the CHECK state exists. The 8-bit modular sum of the header byte, all data bytes and the checksum byte must equal 0x00. Any other result moves to ERR.
  - Undefined: no CHECK state. DATA moves directly to DONE, and no trailing byte is consumed.

## Structure
- Shared package:
  - state enum (IDLE, HEADER, DATA, CHECK, DONE, ERR)
  - byte-lane constant 4
  - default NUM_WORDS
- One sub-module, byte_word_packer: 2-bit lane counter plus 32-bit shift register, with a word_ready pulse output and a synchronous clear.

## Test plan
- Single word, checksum on: start; bytes 01, 20, 08, 00, 05, D2 → imem_we one cycle, addr 0x00000000, wdata 0x20080005; then done=1, cpu_hold=0, error=0.
- Three words with byte_valid toggling every other cycle: words 0x20080005, 0x20090003, 0x01095020 → strobes at addresses 0x0, 0x4, 0x8 in order; done=1; data identical to the gap-free run.
- Header 00, and separately header 11 (17) with NUM_WORDS=16 → error=1, no imem_we, cpu_hold=1.
- Checksum mismatch: bytes 01, 20, 08, 00, 05, D3 → one write of 0x20080005, then error=1, done=0, cpu_hold=1.
- Reset asserted after 2 data bytes → next cycle all outputs at reset values; no strobe; a subsequent start with a valid stream loads correctly.
- start pulsed mid-DATA → ignored; after completion, start in DONE reloads with cpu_hold returning high.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader shared types and constants.
// Optional checksum stage: define IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_e;

  localparam int unsigned BYTE_LANES    = 4;
  localparam int unsigned DEF_NUM_WORDS = 16;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
// master = loader side, slave = stream source / memory side.
interface imem_loader_if;

  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport slave (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

endinterface

// File: rtl/imem_loader_byte_word_packer.sv
// Packs bytes MSB-first into 32-bit words; word_ready flags the 4th byte.
// word is the packed value including the byte being shifted in now.
module byte_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic        word_ready,
  output logic [31:0] word
);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] sr_q, sr_d;

  always_comb begin
    word       = {sr_q[23:0], byte_in};
    word_ready = shift_en && (lane_q == 2'(BYTE_LANES - 1));
    lane_d     = lane_q;
    sr_d       = sr_q;
    if (clr) begin
      lane_d = 2'd0;
      sr_d   = 32'd0;
    end else if (shift_en) begin
      lane_d = lane_q + 2'd1;
      sr_d   = word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q <= 2'd0;
      sr_q   <= 32'd0;
    end else begin
      lane_q <= lane_d;
      sr_q   <= sr_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte stream -> big-endian words -> imem, CPU held until done.
// Define IMEM_LOADER_CHECKSUM_EN for the trailing checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned NUM_WORDS = DEF_NUM_WORDS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          error
);

  state_e      state_q, state_d;
  logic [7:0]  n_q, n_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [7:0]  sum_q, sum_d;
  logic        rdy_q, rdy_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        acc;
  logic        idle_like;
  logic        pk_clr;
  logic        pk_shift;
  logic        pk_ready;
  logic [31:0] pk_word;
  logic [7:0]  sum_nxt;

  assign acc       = bus.byte_valid && rdy_q;
  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE)
                  || (state_q == S_ERR);
  assign pk_clr    = start && idle_like;
  assign pk_shift  = acc && (state_q == S_DATA);
  assign sum_nxt   = sum_q + bus.byte_data;

  byte_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clr        (pk_clr),
    .shift_en   (pk_shift),
    .byte_in    (bus.byte_data),
    .word_ready (pk_ready),
    .word       (pk_word)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wcnt_d  = wcnt_q;
    sum_d   = sum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HEADER;
          wcnt_d  = 8'd0;
          sum_d   = 8'd0;
        end
      end
      S_HEADER: begin
        if (acc) begin
          if (bus.byte_data == 8'd0
              || 32'(bus.byte_data) > NUM_WORDS) begin
            state_d = S_ERR;
          end else begin
            n_d     = bus.byte_data;
            sum_d   = bus.byte_data;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (acc) begin
          sum_d = sum_nxt;
          if (pk_ready) begin
            we_d    = 1'b1;
            addr_d  = {22'd0, wcnt_q, 2'b00};
            wdata_d = pk_word;
            if (wcnt_q == n_q - 8'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = S_CHECK;
`else
              state_d = S_DONE;
`endif
            end else begin
              wcnt_d = wcnt_q + 8'd1;
            end
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (acc) begin
          state_d = (sum_nxt == 8'd0) ? S_DONE : S_ERR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    // outputs registered from the next state so they line up with it
    rdy_d  = (state_d == S_HEADER) || (state_d == S_DATA)
          || (state_d == S_CHECK);
    hold_d = (state_d != S_DONE);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      n_q     <= 8'd0;
      wcnt_q  <= 8'd0;
      sum_q   <= 8'd0;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      wcnt_q  <= wcnt_d;
      sum_q   <= sum_d;
      rdy_q   <= rdy_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.byte_ready = rdy_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign cpu_hold       = hold_q;
  assign done           = done_q;
  assign error          = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random streams against a byte-count model.
// Follows IMEM_LOADER_CHECKSUM_EN the same way the design does.
module tb_imem_loader;

  localparam int NW = 16;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  localparam int P_IDLE = 0;
  localparam int P_HDR  = 1;
  localparam int P_DATA = 2;
  localparam int P_CHK  = 3;
  localparam int P_DONE = 4;
  localparam int P_ERR  = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic cpu_hold, done, error;

  imem_loader_if bus ();

  imem_loader #(.NUM_WORDS(NW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: tracks loader phase from accepted-byte counts
  int          ph = P_IDLE;
  int          e_n = 0;
  int          e_cnt = 0;
  logic [7:0]  msum = 8'd0;
  logic [7:0]  wb[$];
  logic        e_rdy = 1'b0, e_we = 1'b0;
  logic        e_hold = 1'b1, e_done = 1'b0, e_err = 1'b0;
  logic [31:0] e_addr = 32'd0, e_wdata = 32'd0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  always @(negedge clk) begin
    logic [7:0] b;
    bit acc;
    if (cmp_on) begin
      chk("byte_ready", {31'd0, bus.byte_ready}, {31'd0, e_rdy});
      chk("imem_we", {31'd0, bus.imem_we}, {31'd0, e_we});
      chk("imem_addr", bus.imem_addr, e_addr);
      chk("imem_wdata", bus.imem_wdata, e_wdata);
      chk("cpu_hold", {31'd0, cpu_hold}, {31'd0, e_hold});
      chk("done", {31'd0, done}, {31'd0, e_done});
      chk("error", {31'd0, error}, {31'd0, e_err});
      if (bus.imem_we === 1'b1) begin
        wa.push_back(bus.imem_addr);
        wd.push_back(bus.imem_wdata);
      end
    end
    b   = bus.byte_data;
    acc = (bus.byte_valid === 1'b1) && e_rdy;
    e_we = 1'b0;
    if (reset) begin
      ph      = P_IDLE;
      e_addr  = 32'd0;
      e_wdata = 32'd0;
    end else if (ph == P_IDLE || ph == P_DONE || ph == P_ERR) begin
      if (start) ph = P_HDR;
    end else if (ph == P_HDR) begin
      if (acc) begin
        if (b == 8'd0 || int'(b) > NW) ph = P_ERR;
        else begin
          e_n = int'(b); e_cnt = 0; msum = b; wb.delete();
          ph = P_DATA;
        end
      end
    end else if (ph == P_DATA) begin
      if (acc) begin
        wb.push_back(b);
        msum += b;
        e_cnt++;
        if (e_cnt % 4 == 0) begin
          e_we    = 1'b1;
          e_addr  = 32'(4 * (e_cnt / 4 - 1));
          e_wdata = {wb[e_cnt-4], wb[e_cnt-3], wb[e_cnt-2], wb[e_cnt-1]};
          if (e_cnt == 4 * e_n) ph = CK ? P_CHK : P_DONE;
        end
      end
    end else if (ph == P_CHK) begin
      if (acc) ph = (8'(msum + b) == 8'd0) ? P_DONE : P_ERR;
    end
    e_rdy  = (ph == P_HDR || ph == P_DATA || ph == P_CHK);
    e_hold = (ph != P_DONE);
    e_done = (ph == P_DONE);
    e_err  = (ph == P_ERR);
  end

  logic [7:0] stream[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    bit rdy;
    for (int i = 0; i < gap; i++) begin
      bus.byte_valid = 1'b0;
      tick();
      start = 1'b0;
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    n = 0;
    do begin
      rdy = bus.byte_ready;
      tick();
      start = 1'b0;
      n++;
    end while (!rdy && n < 40);
    chk("byte_accept", {31'd0, rdy}, 32'd1);
    bus.byte_valid = 1'b0;
  endtask

  task automatic build(input logic [31:0] w[$], input logic [7:0] hdr,
                       input bit bad);
    logic [7:0] s;
    logic [7:0] x;
    stream.delete();
    stream.push_back(hdr);
    s = hdr;
    foreach (w[i]) begin
      for (int j = 3; j >= 0; j--) begin
        x = w[i][8*j +: 8];
        stream.push_back(x);
        s += x;
      end
    end
    if (CK) stream.push_back(8'(8'd0 - s + {7'd0, bad}));
  endtask

  task automatic do_start();
    wa.delete();
    wd.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_stream(input int gmode);
    int g;
    foreach (stream[i]) begin
      g = (gmode == 0) ? 0 : (gmode == 1) ? 1 : int'($urandom_range(0, 2));
      send_byte(stream[i], g);
    end
    tick();
    tick();
  endtask

  task automatic check_words(input logic [31:0] exp[$]);
    chk("wr_count", 32'(wa.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < wa.size(); i++) begin
      chk("wr_addr", wa[i], 32'(4 * i));
      chk("wr_data", wd[i], exp[i]);
    end
  endtask

  task automatic check_status(input bit d, input bit e);
    chk("st_done", {31'd0, done}, {31'd0, d});
    chk("st_error", {31'd0, error}, {31'd0, e});
    chk("st_hold", {31'd0, cpu_hold}, {31'd0, !d});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w[$];
    logic [31:0] none[$];
    int n;
    bit badh, badc;
    logic [7:0] hdr;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'd0;
    none.delete();
    tick();
    tick();
    cmp_on = 1'b1;
    reset  = 1'b0;
    chk("rst_ready", {31'd0, bus.byte_ready}, 32'd0);
    chk("rst_we", {31'd0, bus.imem_we}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'd0);
    chk("rst_wdata", bus.imem_wdata, 32'd0);
    check_status(1'b0, 1'b0);
    tick();

    // single word
    w = '{32'h20080005};
    build(w, 8'h01, 1'b0);
    if (CK) chk("stream_ck", {24'd0, stream[5]}, 32'h0000_00D2);
    do_start();
    send_stream(0);
    check_words(w);
    check_status(1'b1, 1'b0);

    // three words, valid toggling, then gap-free
    w = '{32'h20080005, 32'h20090003, 32'h01095020};
    build(w, 8'h03, 1'b0);
    do_start();
    send_stream(1);
    check_words(w);
    check_status(1'b1, 1'b0);
    do_start();
    send_stream(0);
    check_words(w);
    check_status(1'b1, 1'b0);

    // bad headers
    stream = '{8'h00};
    do_start();
    send_stream(0);
    check_words(none);
    check_status(1'b0, 1'b1);
    stream = '{8'h11};
    do_start();
    send_stream(0);
    check_words(none);
    check_status(1'b0, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    w = '{32'h20080005};
    build(w, 8'h01, 1'b1);
    chk("stream_bad_ck", {24'd0, stream[5]}, 32'h0000_00D3);
    do_start();
    send_stream(0);
    check_words(w);
    check_status(1'b0, 1'b1);
`endif

    // reset after two data bytes
    w = '{32'h11223344, 32'h55667788};
    build(w, 8'h02, 1'b0);
    do_start();
    for (int i = 0; i < 3; i++) send_byte(stream[i], 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_ready", {31'd0, bus.byte_ready}, 32'd0);
    chk("mid_rst_addr", bus.imem_addr, 32'd0);
    check_status(1'b0, 1'b0);
    tick();
    tick();
    check_words(none);
    do_start();
    send_stream(0);
    check_words(w);
    check_status(1'b1, 1'b0);

    // start mid-DATA is ignored, start in DONE reloads
    w = '{32'hCAFEBABE, 32'h0BADF00D};
    build(w, 8'h02, 1'b0);
    do_start();
    foreach (stream[i]) begin
      if (i == 5) start = 1'b1;
      send_byte(stream[i], 0);
    end
    tick();
    tick();
    check_words(w);
    check_status(1'b1, 1'b0);
    w = '{32'h8C020004};
    build(w, 8'h01, 1'b0);
    do_start();
    chk("reload_hold", {31'd0, cpu_hold}, 32'd1);
    chk("reload_done", {31'd0, done}, 32'd0);
    send_stream(2);
    check_words(w);
    check_status(1'b1, 1'b0);

    // random loads
    for (int t = 0; t < 25; t++) begin
      badh = ($urandom_range(0, 7) == 0);
      badc = CK && ($urandom_range(0, 5) == 0);
      n = int'($urandom_range(1, NW));
      w.delete();
      for (int i = 0; i < n; i++) w.push_back($urandom);
      if (badh) begin
        hdr = ($urandom_range(0, 1) == 0) ? 8'd0
            : 8'($urandom_range(NW + 1, 255));
        stream = '{hdr};
      end else begin
        build(w, 8'(n), badc);
      end
      do_start();
      send_stream(int'($urandom_range(0, 2)));
      check_words(badh ? none : w);
      check_status(!badh && !badc, badh || badc);
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
